// File: rtl/branch_predictor.sv
// Branch predictor: direct-mapped table of 2-bit saturating counters with
// branch targets, plus saturating resolved-branch and mispredict counters.
// Prediction is a combinational read; updates arrive from the MEM stage.

package branch_predictor_pkg;
   typedef logic [31:0] word_t;

   // Counter strength, weakest not-taken to strongest taken; bit 1 is the
   // taken prediction.
   typedef enum logic [1:0] {
      BPRED_NS = 2'b00,
      BPRED_NH = 2'b01,
      BPRED_TH = 2'b10,
      BPRED_TS = 2'b11
   } bpred_t;
endpackage

module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int     IDX_W      = 4,
   parameter bpred_t INIT_STATE = BPRED_TH
) (
   input  logic        CLK,
   input  logic        nRST,
   input  word_t       pred_pc,
   output logic        pred_taken,
   output word_t       pred_target,
   input  logic        upd_en,
   input  word_t       upd_pc,
   input  logic        upd_taken,
   input  word_t       upd_target,
   input  logic        upd_mispred,
   output logic [15:0] mispred_cnt,
   output logic [15:0] branch_cnt
);

   localparam int N_ENT = 1 << IDX_W;
   localparam int TAG_W = 30 - IDX_W;

   logic [N_ENT-1:0] r_valid;
   logic [TAG_W-1:0] r_tag    [N_ENT];
   word_t            r_target [N_ENT];
   bpred_t           r_state  [N_ENT];
   logic [15:0]      r_mispred_cnt;
   logic [15:0]      r_branch_cnt;

   logic [IDX_W-1:0] w_pidx;
   logic [TAG_W-1:0] w_ptag;
   bpred_t           w_pstate;
   logic             w_phit;
   logic [IDX_W-1:0] w_uidx;
   logic [TAG_W-1:0] w_utag;
   logic             w_uhit;
   logic             w_unused_pc_lsbs;

   // Byte offset within the word never distinguishes branches.
   assign w_unused_pc_lsbs = ^{pred_pc[1:0], upd_pc[1:0]};

   assign w_pidx   = pred_pc[IDX_W+1:2];
   assign w_ptag   = pred_pc[31:IDX_W+2];
   assign w_pstate = r_state[w_pidx];
   assign w_phit   = r_valid[w_pidx] && (r_tag[w_pidx] == w_ptag);

   assign w_uidx = upd_pc[IDX_W+1:2];
   assign w_utag = upd_pc[31:IDX_W+2];
   assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);

   // Lookup reads the registered table directly: no bypass from a same-cycle
   // update, so the new contents appear one cycle later.
   always_comb begin
      pred_taken  = w_phit && w_pstate[1];
      pred_target = '0;
      if (pred_taken) begin
         pred_target = r_target[w_pidx];
      end
   end

   assign mispred_cnt = r_mispred_cnt;
   assign branch_cnt  = r_branch_cnt;

   // One step toward strongly-taken (up=1) or strongly-not-taken (up=0).
   function automatic bpred_t f_step(input bpred_t s, input logic up);
      bpred_t n;
      n = s;
      case (s)
         BPRED_NS: n = up ? BPRED_NH : BPRED_NS;
         BPRED_NH: n = up ? BPRED_TH : BPRED_NS;
         BPRED_TH: n = up ? BPRED_TS : BPRED_NH;
         BPRED_TS: n = up ? BPRED_TS : BPRED_TH;
         default:  n = BPRED_NS;
      endcase
      return n;
   endfunction

   // Table update: train on hit, allocate on taken miss, ignore not-taken miss.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_valid <= '0;
         for (int i = 0; i < N_ENT; i++) begin
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_state[i]  <= BPRED_NS;
         end
      end else if (upd_en) begin
         if (w_uhit) begin
            r_state[w_uidx] <= f_step(r_state[w_uidx], upd_taken);
            if (upd_taken) begin
               r_target[w_uidx] <= upd_target;
            end
         end else if (upd_taken) begin
            r_valid[w_uidx]  <= 1'b1;
            r_tag[w_uidx]    <= w_utag;
            r_target[w_uidx] <= upd_target;
            r_state[w_uidx]  <= INIT_STATE;
         end
      end
   end

   // Saturating statistics counters.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_branch_cnt  <= '0;
         r_mispred_cnt <= '0;
      end else if (upd_en) begin
         if (r_branch_cnt != 16'hFFFF) begin
            r_branch_cnt <= r_branch_cnt + 16'd1;
         end
         if (upd_mispred && (r_mispred_cnt != 16'hFFFF)) begin
            r_mispred_cnt <= r_mispred_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a vector table stepping through
// training, aliasing and same-cycle read/update, then hand-written sequences
// for counter saturation and asynchronous reset.

module tb_branch_predictor;

   logic        CLK;
   logic        nRST;
   logic [31:0] pred_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        upd_en;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_mispred;
   logic [15:0] mispred_cnt;
   logic [15:0] branch_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   branch_predictor dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .pred_pc     (pred_pc),
      .pred_taken  (pred_taken),
      .pred_target (pred_target),
      .upd_en      (upd_en),
      .upd_pc      (upd_pc),
      .upd_taken   (upd_taken),
      .upd_target  (upd_target),
      .upd_mispred (upd_mispred),
      .mispred_cnt (mispred_cnt),
      .branch_cnt  (branch_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic e_tk, input logic [31:0] e_tgt,
                            input logic [15:0] e_bc, input logic [15:0] e_mc);
      check({tag, " pred_taken"},  {31'd0, pred_taken}, {31'd0, e_tk});
      check({tag, " pred_target"}, pred_target, e_tgt);
      check({tag, " branch_cnt"},  {16'd0, branch_cnt}, {16'd0, e_bc});
      check({tag, " mispred_cnt"}, {16'd0, mispred_cnt}, {16'd0, e_mc});
   endtask

   // Inputs applied for one cycle; expected outputs are those seen during
   // that cycle, i.e. before the update takes effect at the next edge.
   typedef struct {
      logic        en;
      logic [31:0] upc;
      logic        tk;
      logic [31:0] utgt;
      logic        mis;
      logic [31:0] ppc;
      logic        e_tk;
      logic [31:0] e_tgt;
      logic [15:0] e_bc;
      logic [15:0] e_mc;
   } vec_t;

   localparam int NV = 22;
   vec_t vecs [NV];

   initial begin
      //            en    upc       tk    utgt        mis   ppc       e_tk  e_tgt       bc     mc
      vecs[0]  = '{1'b0, 32'h00, 1'b0, 32'h0,     1'b0, 32'h40, 1'b0, 32'h0,     16'd0, 16'd0};
      vecs[1]  = '{1'b1, 32'h40, 1'b1, 32'h100,   1'b1, 32'h40, 1'b0, 32'h0,     16'd0, 16'd0};
      vecs[2]  = '{1'b0, 32'h00, 1'b0, 32'h0,     1'b0, 32'h40, 1'b1, 32'h100,   16'd1, 16'd1};
      vecs[3]  = '{1'b1, 32'h40, 1'b0, 32'h0,     1'b1, 32'h40, 1'b1, 32'h100,   16'd1, 16'd1};
      vecs[4]  = '{1'b0, 32'h00, 1'b0, 32'h0,     1'b0, 32'h40, 1'b0, 32'h0,     16'd2, 16'd2};
      vecs[5]  = '{1'b1, 32'h40, 1'b0, 32'h0,     1'b0, 32'h43, 1'b0, 32'h0,     16'd2, 16'd2};
      vecs[6]  = '{1'b1, 32'h40, 1'b1, 32'h200,   1'b1, 32'h40, 1'b0, 32'h0,     16'd3, 16'd2};
      vecs[7]  = '{1'b1, 32'h40, 1'b1, 32'h204,   1'b1, 32'h40, 1'b0, 32'h0,     16'd4, 16'd3};
      vecs[8]  = '{1'b1, 32'h40, 1'b1, 32'h208,   1'b0, 32'h41, 1'b1, 32'h204,   16'd5, 16'd4};
      vecs[9]  = '{1'b1, 32'h40, 1'b1, 32'h208,   1'b0, 32'h40, 1'b1, 32'h208,   16'd6, 16'd4};
      vecs[10] = '{1'b1, 32'h40, 1'b0, 32'h0,     1'b0, 32'h40, 1'b1, 32'h208,   16'd7, 16'd4};
      vecs[11] = '{1'b1, 32'h40, 1'b0, 32'h0,     1'b0, 32'h40, 1'b1, 32'h208,   16'd8, 16'd4};
      vecs[12] = '{1'b0, 32'h40, 1'b1, 32'hDEAD,  1'b1, 32'h40, 1'b0, 32'h0,     16'd9, 16'd4};
      vecs[13] = '{1'b0, 32'h00, 1'b0, 32'h0,     1'b0, 32'h40, 1'b0, 32'h0,     16'd9, 16'd4};
      vecs[14] = '{1'b1, 32'h80, 1'b0, 32'h0,     1'b0, 32'h80, 1'b0, 32'h0,     16'd9, 16'd4};
      vecs[15] = '{1'b1, 32'h80, 1'b1, 32'h300,   1'b1, 32'h40, 1'b0, 32'h0,     16'd10, 16'd4};
      vecs[16] = '{1'b0, 32'h00, 1'b0, 32'h0,     1'b0, 32'h80, 1'b1, 32'h300,   16'd11, 16'd5};
      vecs[17] = '{1'b0, 32'h00, 1'b0, 32'h0,     1'b0, 32'h40, 1'b0, 32'h0,     16'd11, 16'd5};
      vecs[18] = '{1'b1, 32'h44, 1'b1, 32'h444,   1'b0, 32'h44, 1'b0, 32'h0,     16'd11, 16'd5};
      vecs[19] = '{1'b0, 32'h00, 1'b0, 32'h0,     1'b0, 32'h44, 1'b1, 32'h444,   16'd12, 16'd5};
      vecs[20] = '{1'b0, 32'h00, 1'b0, 32'h0,     1'b0, 32'h80, 1'b1, 32'h300,   16'd12, 16'd5};
      vecs[21] = '{1'b0, 32'h00, 1'b0, 32'h0,     1'b0, 32'hC4, 1'b0, 32'h0,     16'd12, 16'd5};

      nRST        = 1'b0;
      pred_pc     = 32'h40;
      upd_en      = 1'b0;
      upd_pc      = '0;
      upd_taken   = 1'b0;
      upd_target  = '0;
      upd_mispred = 1'b0;

      repeat (2) @(negedge CLK);
      #1 check_all("in_reset", 1'b0, 32'h0, 16'd0, 16'd0);

      @(negedge CLK);
      nRST = 1'b1;
      #1 check_all("first_after_reset", 1'b0, 32'h0, 16'd0, 16'd0);

      for (int i = 0; i < NV; i++) begin
         @(negedge CLK);
         upd_en      = vecs[i].en;
         upd_pc      = vecs[i].upc;
         upd_taken   = vecs[i].tk;
         upd_target  = vecs[i].utgt;
         upd_mispred = vecs[i].mis;
         pred_pc     = vecs[i].ppc;
         #1 check_all($sformatf("vec%0d", i), vecs[i].e_tk, vecs[i].e_tgt,
                      vecs[i].e_bc, vecs[i].e_mc);
      end

      // Fresh reset, then a long stream of mispredicted taken updates.
      @(negedge CLK);
      upd_en = 1'b0;
      nRST   = 1'b0;
      @(negedge CLK);
      nRST = 1'b1;
      #1 check_all("reset2", 1'b0, 32'h0, 16'd0, 16'd0);

      @(negedge CLK);
      upd_en      = 1'b1;
      upd_pc      = 32'h40;
      upd_taken   = 1'b1;
      upd_target  = 32'h100;
      upd_mispred = 1'b1;
      pred_pc     = 32'h40;
      repeat (65534) @(posedge CLK);
      #1 check_all("near_sat", 1'b1, 32'h100, 16'hFFFE, 16'hFFFE);
      repeat (70000 - 65534) @(posedge CLK);
      #1 check_all("saturated", 1'b1, 32'h100, 16'hFFFF, 16'hFFFF);

      // Reset asserted mid-cycle with an update pending: outputs drop at once.
      @(negedge CLK);
      #2 nRST = 1'b0;
      #1 check_all("async_reset", 1'b0, 32'h0, 16'd0, 16'd0);
      repeat (2) @(posedge CLK);
      #1 check_all("reset_held_upd", 1'b0, 32'h0, 16'd0, 16'd0);

      @(negedge CLK);
      upd_en = 1'b0;
      nRST   = 1'b1;
      #1 check_all("release", 1'b0, 32'h0, 16'd0, 16'd0);
      @(negedge CLK);
      #1 check_all("post_release", 1'b0, 32'h0, 16'd0, 16'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
